uart_rx_fifo_param: RTL
=======================

// Module: uart_rx_fifo_param
// PURPOSE
//   Parametrised UART receiver, successor to the fixed 8N1 receiver.
//   - Configurable baud divisor, data width and stop bits; optional parity check.
//   - Framing-error and overrun reporting.
//   - Received words are buffered in a small FIFO behind a valid/ready output, so
//     thread FSMs can consume them without missing frames.
// PARAMETERS
//   CLKS_PER_BIT  5208  clk cycles per bit (>=4)
//   DATA_BITS     8     payload bits per frame (5..9), LSB first
//   STOP_BITS     1     1 or 2 stop bits checked
//   FIFO_DEPTH    4     receive FIFO entries (power of 2, >=2)
//   PARITY_ODD    0     0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//   clk         in   1                          clock
//   RST         in   1                          reset: synchronous, active-high
//   rxd         in   1                          asynchronous serial line, idle high
//   dout        out  DATA_BITS                  FIFO head word
//   valid       out  1                          FIFO not empty
//   ready       in   1                          consumer accepts; pop when valid&&ready
//   count       out  $clog2(FIFO_DEPTH+1)       FIFO occupancy
//   frame_err   out  1                          1-cycle pulse: a stop bit sampled 0
//   overrun     out  1                          1-cycle pulse: good frame dropped, FIFO full
//   parity_err  out  1                          1-cycle pulse: parity mismatch; tied 0 without macro
// BEHAVIOUR
//   Reset values: all outputs 0; FSM in IDLE; FIFO empty; synchroniser flops = 1.
//   Reset mid-frame aborts the frame and flushes the FIFO.
//   Input sync: 2-flop synchroniser on rxd, plus a previous-value flop for edge detect.
//   Bit-timing counter reload values:
//     - CLKS_PER_BIT/2-1 for the half-bit delay.
//     - CLKS_PER_BIT-1 for each full bit.
//     - A bit is sampled when the counter reaches 0.
//   FSM states:
//     - IDLE: on a synced 1->0 edge, load half-bit and go to START. A line held low
//       (break) does not retrigger.
//     - START: on sample, rxd=1 returns to IDLE (glitch reject); rxd=0 loads a full bit,
//       sets idx=0, goes to DATA.
//     - DATA: shift the sample into bit idx. After idx=DATA_BITS-1 go to PARITY if the
//       macro is defined, else to STOP.
//     - PARITY: check the sample against the XOR of the data bits (inverted if
//       PARITY_ODD), then go to STOP.
//     - STOP: sample STOP_BITS stop bits, one per full bit period. At the last sample go
//       to IDLE immediately (mid-bit resync).
//   Frame outcome at the last stop sample:
//     - Any stop bit = 0: frame_err pulses next cycle; word discarded.
//     - Parity fail: parity_err pulses; word discarded.
//     - Both checks fail: both pulses fire.
//     - Otherwise push the word.
//   Latency: valid/dout update one cycle after the last stop sample.
//   FIFO boundaries:
//     - Push while full: word dropped, overrun pulses, contents unchanged.
//     - Push and pop in the same cycle when full: both happen, no overrun, count
//       unchanged.
//     - Push and pop when empty: the pop is ignored (valid=0), the push lands.
//     - Pointers wrap modulo FIFO_DEPTH; count saturates at neither end beyond
//       0..FIFO_DEPTH.
//     - dout is stable while valid && !ready.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - A PARITY state follows DATA; each frame has one extra bit.
//     - parity_err is driven.
//   UART_RX_PARITY_EN undefined:
//     - No PARITY state; the frame is start + DATA_BITS + STOP_BITS.
//     - parity_err = 0.
// STRUCTURE
//   Package uart_pkg:
//     - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
//     - Function cnt_w(CLKS_PER_BIT) returning the counter width.
//     - Constant LINE_IDLE = 1'b1.
//   Sub-module uart_sync_fifo: DATA_BITS x FIFO_DEPTH, push/pop/full/empty/count.
//   Top: synchroniser, FSM, bit counter, shift register, error pulses.
// TESTING (bench CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
//   1. 8N1 frame 0x55, ready=1 -> valid=1, dout=0x55 for one cycle, 1 cycle after
//      stop mid-bit; count returns to 0.
//   2. rxd low 5 cycles then high -> START rejects; no valid, no error pulses.
//   3. 0xA3 with stop bit 0, then line high, then 0x3C -> one frame_err pulse;
//      only 0x3C appears.
//   4. ready=0, frames 0x01..0x05 -> count=4, overrun pulses once on 0x05;
//      then ready=1 pops 0x01,0x02,0x03,0x04 in order.
//   5. UART_RX_PARITY_EN, even: 0x07 with parity 0 -> parity_err pulse, no push;
//      parity 1 -> 0x07 delivered.
//   6. RST during data bit 3 -> outputs 0, count 0; next frame 0x81 received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Width needed to hold CLKS_PER_BIT-1 in the bit-timing counter.
  function automatic int unsigned cnt_w(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for received words; a push into a full FIFO only lands when a pop frees a slot that cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver with error pulses and an output FIFO.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                              clk,
  input  logic                              RST,
  input  logic                              rxd,
  output logic [DATA_BITS-1:0]              dout,
  output logic                              valid,
  input  logic                              ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              frame_err,
  output logic                              overrun,
  output logic                              parity_err
);

  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  rx_state_t            state, state_nxt;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 stop_bad, stop_bad_nxt;
  logic                 par_bad, par_bad_nxt;
  logic                 sample, finish, end_ferr, end_perr;
  logic                 push, full, empty;

  assign sample = (cnt == '0);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = sample ? cnt : cnt - CW'(1);
    idx_nxt      = idx;
    shreg_nxt    = shreg;
    stop_idx_nxt = stop_idx;
    stop_bad_nxt = stop_bad;
    par_bad_nxt  = par_bad;
    finish       = 1'b0;
    end_ferr     = 1'b0;
    end_perr     = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx_sync) begin
        cnt_nxt   = HALF_BIT;
        state_nxt = START;
      end
      START: if (sample) begin
        if (rx_sync) state_nxt = IDLE;
        else begin
          cnt_nxt      = FULL_BIT;
          idx_nxt      = '0;
          stop_idx_nxt = 1'b0;
          stop_bad_nxt = 1'b0;
          par_bad_nxt  = 1'b0;
          state_nxt    = DATA;
        end
      end
      DATA: if (sample) begin
        shreg_nxt[idx] = rx_sync;
        cnt_nxt        = FULL_BIT;
        if (32'(idx) == DATA_BITS - 1) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end else idx_nxt = idx + IW'(1);
      end
      PARITY: if (sample) begin
        par_bad_nxt = rx_sync != ((^shreg) ^ ODD);
        cnt_nxt     = FULL_BIT;
        state_nxt   = STOP;
      end
      STOP: if (sample) begin
        if (!rx_sync) stop_bad_nxt = 1'b1;
        // Leave at the last mid-bit sample so the next start edge is caught promptly.
        if (32'(stop_idx) == STOP_BITS - 1) begin
          finish    = 1'b1;
          end_ferr  = stop_bad || !rx_sync;
`ifdef UART_RX_PARITY_EN
          end_perr  = par_bad;
`endif
          state_nxt = IDLE;
        end else begin
          stop_idx_nxt = stop_idx + 1'b1;
          cnt_nxt      = FULL_BIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push = finish && !end_ferr && !end_perr;

  always_ff @(posedge clk) begin
    if (RST) begin
      rx_meta    <= LINE_IDLE;
      rx_sync    <= LINE_IDLE;
      rx_prev    <= LINE_IDLE;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      stop_idx   <= 1'b0;
      stop_bad   <= 1'b0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      stop_idx   <= stop_idx_nxt;
      stop_bad   <= stop_bad_nxt;
      par_bad    <= par_bad_nxt;
      frame_err  <= end_ferr;
      overrun    <= push && full && !ready;
      parity_err <= end_perr;
    end
  end

  assign valid = !empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (push),
    .din   (shreg_nxt),
    .pop   (ready),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule
